// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instr_fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // One FIFO entry: the fetch address travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory read port and decode handshake bundle
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic            mem_renable;
  logic [XLEN-1:0] mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  // Fetch stage side: drives the memory request and the decode-facing outputs.
  modport master (
    output mem_addr,
    output mem_renable,
    input  mem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // Memory + decode side.
  modport slave (
    input  mem_addr,
    input  mem_renable,
    output mem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - small {pc, instr} FIFO with flush and head hold
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_data,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  hold_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_en;
  logic          pop_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Flush dominates both push and pop; push into a full FIFO is discarded.
  always_comb begin
    push_en = push & ~flush & ~full;
    pop_en  = pop & ~flush & ~empty;
  end

  // Storage array; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers, occupancy and the last presented head (shown while empty).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (!empty) begin
        hold_q <= mem[rd_ptr_q];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_en) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        case ({push_en, pop_en})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Present the live head, or the last value decode saw when nothing is valid.
  always_comb begin
    head_data = hold_q;
    if (!empty) begin
      head_data = mem[rd_ptr_q];
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, memory request credit logic and fetch FIFO
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fetch_en,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  instr_fetch_if.master    bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OCC_W = CW + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q;

  fetch_entry_t    push_data;
  fetch_entry_t    head_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            pop;
  logic            issue;
  logic [OCC_W-1:0] occ;

  // Credit check: a request is only issued if its word is guaranteed a slot,
  // counting stored entries plus the word in flight, minus this cycle's pop.
  always_comb begin
    pop       = ~fifo_empty & bus.out_ready;
    occ       = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);
    issue     = resetn & fetch_en & ~redirect_valid & (occ < OCC_W'(DEPTH));
    fifo_push = inflight_q & ~redirect_valid & ~fifo_full;
    push_data = '{pc: req_pc_q, instr: bus.mem_rdata};
  end

  // PC and in-flight tracking; a redirect overrides everything and drops the
  // response that is still on its way from memory.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= align_pc(redirect_pc);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + PC_INCR;
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.mem_addr    = pc_q;
  assign bus.mem_renable = issue;
  assign bus.out_valid   = ~fifo_empty;
  assign bus.out_pc      = head_data.pc;
  assign bus.out_instr   = head_data.instr;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the synchronous instruction memory. Holds the program counter, issues one word-aligned read per cycle to the memory's 1-cycle-latency read port, captures returned words into a small FIFO, and presents {pc, instruction} pairs to decode over a valid/ready handshake. Branch/jump redirects from execute flush all fetched and in-flight work.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- fetch_en  in  1  high allows new requests; low holds PC (in-flight word still completes)
- redirect_valid  in  1  one-cycle pulse: taken branch/jump
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0)
- mem_addr  out  32  read address, always pc_q
- mem_renable  out  1  read request this cycle
- mem_rdata  in  32  read data, valid the cycle after a request
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  instruction at FIFO head
- out_pc  out  32  address of out_instr

## Operation
- Reset (async assert): pc_q=RESET_PC, inflight=0, FIFO empty; mem_renable=0, out_valid=0, out_instr=0, out_pc=0, mem_addr=RESET_PC.
- pop = out_valid & out_ready.
- Issue condition: fetch_en & !redirect_valid & (count + inflight − pop < DEPTH). When true: mem_renable=1, pc_q += 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), inflight<=1, req_pc<=pc_q. Otherwise inflight<=0.
- Response: in cycle with inflight=1 and no redirect, {req_pc, mem_rdata} pushed into FIFO at that edge.
- Push and pop in same cycle: both happen, count unchanged. Push never occurs when full (guaranteed by credit rule; assertion in bench).
- Redirect (highest priority): mem_renable=0; pc_q<=redirect_pc & ~3; FIFO cleared; inflight<=0 so the response arriving next cycle is dropped; pop that cycle is ignored for state (entries already cleared).
- out_instr/out_pc hold their last value while out_valid=0; must be stable while out_valid=1 and out_ready=0.
- mem_renable never asserted while resetn=0.

## Timing
- Reset release edge E0: request RESET_PC in cycle 0, mem_rdata valid cycle 1, out_valid=1 cycle 2 (fetch-to-decode latency 2).
- Sustained throughput 1 instruction/cycle with out_ready=1 and DEPTH=2.
- out_ready low: FIFO fills, at most one more word in flight; requests stop until a pop frees credit, resume the same cycle as the pop.
- Redirect at cycle N: request redirect_pc cycle N+1, out_valid with out_pc=redirect_pc cycle N+3; out_valid=0 in N+1, N+2.
- fetch_en low: no new request; outstanding word still pushed.
- Reset mid-operation: all state cleared immediately, in-flight response discarded.

## Structure
- Shared package: RESET_PC default, instruction width (32), PC increment (4), NOP encoding 32'h0000_0013 for bench fill.
- One sub-module: fetch_fifo (parameter DEPTH, width 64 = {pc, instr}, push/pop/flush, count, full/empty; flush dominates push).
- Top holds pc_q, inflight, req_pc, credit logic.

## Test plan
- Reset, memory words 0x00000013,0x00100093,... at 0,4,8; out_ready=1 -> out_valid from cycle 2, out_pc 0,4,8,... one per cycle, out_instr matches memory.
- out_ready low for 5 cycles after first word -> exactly 2 entries held, mem_renable=0 while full, no lost/duplicated PC on release.
- redirect_valid with redirect_pc=0x00000103 while FIFO full and request in flight -> next out_pc=0x100, stale words never appear, out_valid low 2 cycles.
- pc_q at 0xFFFFFFFC, continuous fetch -> out_pc sequence 0xFFFFFFFC, 0x00000000.
- fetch_en low mid-stream -> one outstanding word delivered, then mem_renable=0; on fetch_en high, fetch resumes at next sequential PC.
- resetn asserted with word in flight and FIFO non-empty -> out_valid=0 immediately, first post-reset out_pc=RESET_PC.
